riscv_icache: RTL

RISCV_ICACHE -- requirements
Module: riscv_icache

---
 rtl/riscv_icache.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_icache.sv
// riscv_icache -- direct-mapped instruction cache, 64 lines x 16 bytes.
//
// Lookup is fully combinational from register-based tag/valid/data arrays,
// so a hit returns the instruction in the same cycle the pc is presented.
// A miss stalls the core, latches the line address and refills the line
// from memory one 32-bit beat at a time (beats 0..3, in order).
//
// Address split: offset = pc[3:2], index = pc[9:4], tag = pc[63:10].
//
// Ports:
//   i_riscv_icache_clk        clock (rising edge)
//   i_riscv_icache_rst        asynchronous active-low reset
//   i_riscv_icache_pc         fetch address
//   i_riscv_icache_flush      fence.i, invalidate every line
//   o_riscv_icache_inst       instruction (NOP 0x00000013 when not hitting)
//   o_riscv_icache_stall      fetch stall
//   o_riscv_icache_mem_req    refill request, high for the whole refill
//   o_riscv_icache_mem_addr   refill line address (bits [3:0] = 0)
//   i_riscv_icache_mem_valid  refill beat valid
//   i_riscv_icache_mem_data   refill beat data
//   o_riscv_icache_hit_cnt    hit counter  (RISCV_ICACHE_PERF_CNT_EN only)
//   o_riscv_icache_miss_cnt   miss counter (RISCV_ICACHE_PERF_CNT_EN only)
//
// Optional feature: define RISCV_ICACHE_PERF_CNT_EN to add the two
// wrapping 32-bit performance counters.
//
// state  | meaning
// IDLE   | lookup; a miss latches the line address and starts a refill
// REFILL | requesting memory, writing beats into the latched line

module riscv_icache (
    input  logic        i_riscv_icache_clk,
    input  logic        i_riscv_icache_rst,
    input  logic [63:0] i_riscv_icache_pc,
    input  logic        i_riscv_icache_flush,
    output logic [31:0] o_riscv_icache_inst,
    output logic        o_riscv_icache_stall,
    output logic        o_riscv_icache_mem_req,
    output logic [63:0] o_riscv_icache_mem_addr,
    input  logic        i_riscv_icache_mem_valid,
    input  logic [31:0] i_riscv_icache_mem_data
`ifdef RISCV_ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] o_riscv_icache_hit_cnt,
    output logic [31:0] o_riscv_icache_miss_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] valid_q, valid_d;
    logic [59:0] line_q,  line_d;   // latched pc[63:4] of the line being refilled
    logic [1:0]  beat_q,  beat_d;
    logic        pend_q,  pend_d;   // flush seen during refill: do not validate

    logic [53:0] tag_q  [64];
    logic [31:0] data_q [64][4];

    logic [5:0]  lk_idx;
    logic [1:0]  lk_off;
    logic [53:0] lk_tag;
    logic [5:0]  rf_idx;
    logic [53:0] rf_tag;
    logic        hit;
    logic        data_we;
    logic        tag_we;
    logic        stall_c;
    logic [31:0] inst_c;
    logic        unused_pc;

    assign lk_idx    = i_riscv_icache_pc[9:4];
    assign lk_off    = i_riscv_icache_pc[3:2];
    assign lk_tag    = i_riscv_icache_pc[63:10];
    assign rf_idx    = line_q[5:0];
    assign rf_tag    = line_q[59:6];
    assign unused_pc = ^i_riscv_icache_pc[1:0];

    assign hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_ff @(posedge i_riscv_icache_clk or negedge i_riscv_icache_rst) begin
        if (!i_riscv_icache_rst) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        line_d  = line_q;
        beat_d  = beat_q;
        pend_d  = pend_q;
        stall_c = 1'b0;
        inst_c  = NOP;
        data_we = 1'b0;
        tag_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (i_riscv_icache_flush) begin
                    valid_d = '0;
                end
                if (hit) begin
                    inst_c = data_q[lk_idx][lk_off];
                end else begin
                    stall_c = 1'b1;
                    state_d = S_REFILL;
                    line_d  = i_riscv_icache_pc[63:4];
                    beat_d  = 2'd0;
                end
            end
            S_REFILL: begin
                stall_c = 1'b1;
                if (i_riscv_icache_flush) begin
                    valid_d = '0;
                    pend_d  = 1'b1;
                end
                if (i_riscv_icache_mem_valid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        // A flush anywhere in the refill, including this
                        // very edge, leaves the new line invalid.
                        tag_we          = 1'b1;
                        valid_d[rf_idx] = ~(pend_q | i_riscv_icache_flush);
                        pend_d          = 1'b0;
                        state_d         = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tag/data arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge i_riscv_icache_clk) begin
        if (data_we) begin
            data_q[rf_idx][beat_q] <= i_riscv_icache_mem_data;
        end
        if (tag_we) begin
            tag_q[rf_idx] <= rf_tag;
        end
    end

    // During reset the lookup misses (valid cleared), which would raise
    // stall; the core must see stall low while reset is held.
    assign o_riscv_icache_stall    = stall_c & i_riscv_icache_rst;
    assign o_riscv_icache_inst     = inst_c;
    assign o_riscv_icache_mem_req  = (state_q == S_REFILL);
    assign o_riscv_icache_mem_addr = {line_q, 4'b0000};

`ifdef RISCV_ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge i_riscv_icache_clk or negedge i_riscv_icache_rst) begin
        if (!i_riscv_icache_rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign o_riscv_icache_hit_cnt  = hit_cnt_q;
    assign o_riscv_icache_miss_cnt = miss_cnt_q;
`endif

endmodule
